apb_slave_ctrl: RTL
===================

// Module: apb_slave_ctrl
// PURPOSE
//  Parametrised APB4 slave front-end between the APB bus and the timer register file.
//  Adds programmable wait states, address range/alignment decode, pstrb byte-mask export,
//  registered read data and transfer abort handling. Emits single-cycle reg_wr_en/reg_rd_en strobes.
// PARAMETERS
//  DATA_SIZE    32  APB data width (multiple of 8)
//  ADDR_SIZE    32  APB address width
//  PSTRB_SIZE   DATA_SIZE/8  byte strobes (derived; do not override)
//  WAIT_CYCLES  1   wait states inserted before pready (0..15)
//  ADDR_RANGE   'h400  decoded byte range; paddr >= ADDR_RANGE is a decode error
// PORTS
//  pclk        in   1           APB clock
//  prst_n      in   1           async active-low reset
//  psel        in   1           slave select
//  penable     in   1           access phase
//  pwrite      in   1           1=write 0=read
//  paddr       in   ADDR_SIZE   byte address
//  pwdata      in   DATA_SIZE   write data
//  pstrb       in   PSTRB_SIZE  write byte strobes
//  prdata      out  DATA_SIZE   read data, valid only while pready & !pwrite
//  pready      out  1           transfer complete
//  pslverr     out  1           error response, valid only while pready
//  reg_addr    out  ADDR_SIZE   latched address to register file
//  reg_wdata   out  DATA_SIZE   latched write data
//  reg_wmask   out  DATA_SIZE   byte mask expanded from latched pstrb
//  reg_wr_en   out  1           1-cycle write commit strobe
//  reg_rd_en   out  1           1-cycle read strobe (clear-on-read side effects)
//  reg_rdata   in   DATA_SIZE   register file read data (combinational on reg_addr)
//  reg_err     in   1           register file error for current reg_addr
// BEHAVIOUR
//  - One clock pclk; reset prst_n asynchronous active-low. Reset: state IDLE, all outputs 0.
//  - FSM IDLE/WAIT/RESP. IDLE & psel & !penable (setup): latch paddr,pwdata,pstrb,pwrite;
//    load cnt=WAIT_CYCLES; go RESP if WAIT_CYCLES==0 else WAIT.
//  - WAIT: cnt decrements each cycle; cnt==1 -> RESP. psel low in WAIT -> abort to IDLE, no strobe, no pready.
//  - RESP: pready=1 (registered state output) for exactly one cycle; always -> IDLE next cycle.
//    Total access-phase length = WAIT_CYCLES+1 cycles. Back-to-back setup in cycle after RESP accepted.
//  - reg_wr_en/reg_rd_en: asserted only in RESP, gated by psel & penable & !err, one pulse per transfer.
//  - prdata registered: captured from reg_rdata on entry to RESP; forced 0 on write or error.
//  - err = latched decode error (paddr >= ADDR_RANGE, or paddr[1:0]!=0) | read with pstrb!=0 | reg_err.
//    pslverr = err in RESP only; an errored write does NOT commit, errored read returns 0.
//  - Write with pstrb==0: no error, reg_wr_en pulses with reg_wmask=0 (no byte modified).
//  - reg_wmask byte i = {8{pstrb_q[i]}}.
//  - penable asserted in IDLE without prior setup: ignored, stays IDLE.
//  - prst_n low mid-transfer: immediate return to IDLE, outputs 0, no strobe after release.
// CONFIGURATION
//  APB_PPROT_CHECK_EN defined: adds port pprot in 3; latched at setup; write with pprot[0]==0
//    (non-privileged) -> pslverr=1, no reg_wr_en. Reads unaffected.
//  Undefined: no pprot port, no privilege check.
// STRUCTURE
//  apb_pkg: FSM state localparams (ST_IDLE/ST_WAIT/ST_RESP), WAIT counter width
//    ($clog2(16)), error-cause bit positions.
//  Sub-module apb_wait_ctr: loadable down-counter with done flag; FSM and decode stay in apb_slave_ctrl.
// TESTING
//  1 WAIT_CYCLES=0, write 0xDEADBEEF @0x10 pstrb=F -> pready on first access cycle, reg_wr_en 1 pulse, wmask=0xFFFFFFFF.
//  2 WAIT_CYCLES=3, read @0x04, reg_rdata=0x1234 -> pready after 3 wait cycles, prdata=0x1234, pslverr=0.
//  3 write @0x400 (out of range) and @0x06 (misaligned) -> pslverr=1 with pready, no reg_wr_en.
//  4 write pstrb=4'b0101 -> reg_wmask=0x00FF00FF; read with pstrb=1 -> pslverr=1, prdata=0.
//  5 WAIT_CYCLES=3, psel drops in 2nd wait cycle -> IDLE, no pready, no strobes; next transfer normal.
//  6 prst_n low during WAIT -> all outputs 0 same cycle; with APB_PPROT_CHECK_EN, write pprot=0 -> pslverr=1.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared constants for the APB slave front-end: FSM state encodings, wait-counter width
// and bit positions of the individual error causes folded into pslverr.
package apb_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Wide enough for the largest wait-state setting (15).
    localparam int CNT_W = $clog2(16);

    localparam int ERR_RANGE = 0;  // paddr beyond decoded window
    localparam int ERR_ALIGN = 1;  // paddr not word aligned
    localparam int ERR_RSTRB = 2;  // read issued with non-zero pstrb
    localparam int ERR_REG   = 3;  // register file rejected the address
    localparam int ERR_PROT  = 4;  // non-privileged write
    localparam int ERR_W     = 5;

    typedef logic [ERR_W-1:0] err_vec_t;

endpackage

// File: rtl/apb_wait_ctr.sv
// Loadable down-counter for APB wait states; done_o flags the last wait cycle (count of one).
module apb_wait_ctr
    import apb_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/apb_slave_ctrl.sv
// APB4 slave front-end for the timer register file: wait states, decode, strobes, registered read data.
// Optional privilege check on writes is enabled by defining APB_PPROT_CHECK_EN.
module apb_slave_ctrl
    import apb_pkg::*;
#(
    parameter int                   DATA_SIZE   = 32,
    parameter int                   ADDR_SIZE   = 32,
    localparam int                  PSTRB_SIZE  = DATA_SIZE / 8,
    parameter int                   WAIT_CYCLES = 1,
    parameter logic [ADDR_SIZE-1:0] ADDR_RANGE  = 'h400
) (
    input  logic                  pclk,
    input  logic                  prst_n,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_SIZE-1:0]  paddr,
    input  logic [DATA_SIZE-1:0]  pwdata,
    input  logic [PSTRB_SIZE-1:0] pstrb,
`ifdef APB_PPROT_CHECK_EN
    input  logic [2:0]            pprot,
`endif
    output logic [DATA_SIZE-1:0]  prdata,
    output logic                  pready,
    output logic                  pslverr,
    output logic [ADDR_SIZE-1:0]  reg_addr,
    output logic [DATA_SIZE-1:0]  reg_wdata,
    output logic [DATA_SIZE-1:0]  reg_wmask,
    output logic                  reg_wr_en,
    output logic                  reg_rd_en,
    input  logic [DATA_SIZE-1:0]  reg_rdata,
    input  logic                  reg_err
);

    logic [1:0]            state_q, state_d;
    logic [ADDR_SIZE-1:0]  addr_q, addr_d;
    logic [DATA_SIZE-1:0]  wdata_q, wdata_d;
    logic [PSTRB_SIZE-1:0] strb_q, strb_d;
    logic                  write_q, write_d;
    err_vec_t              cause_q, cause_d;
    logic [DATA_SIZE-1:0]  prdata_q, prdata_d;

    logic                  setup;
    err_vec_t              setup_cause, entry_cause;
    logic                  entry_write;
    logic [DATA_SIZE-1:0]  entry_rdata;
    logic                  ctr_load, ctr_dec, ctr_done;

`ifdef APB_PPROT_CHECK_EN
    logic unused_pprot;
    assign unused_pprot = ^pprot[2:1];
`endif

    assign setup = (state_q == ST_IDLE) && psel && !penable;

    always_comb begin
        setup_cause            = '0;
        setup_cause[ERR_RANGE] = (paddr >= ADDR_RANGE);
        setup_cause[ERR_ALIGN] = |paddr[1:0];
        setup_cause[ERR_RSTRB] = !pwrite && (|pstrb);
`ifdef APB_PPROT_CHECK_EN
        setup_cause[ERR_PROT]  = pwrite && !pprot[0];
`else
        setup_cause[ERR_PROT]  = 1'b0;
`endif
    end

    // Values sampled on the edge that enters RESP; with zero wait states that edge is the setup edge.
    always_comb begin
        entry_cause          = setup ? setup_cause : cause_q;
        entry_cause[ERR_REG] = reg_err;
        entry_write          = setup ? pwrite : write_q;
        entry_rdata          = (entry_write || (|entry_cause)) ? '0 : reg_rdata;
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        strb_d   = strb_q;
        write_d  = write_q;
        cause_d  = cause_q;
        prdata_d = prdata_q;
        ctr_load = 1'b0;
        ctr_dec  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (setup) begin
                    addr_d   = paddr;
                    wdata_d  = pwdata;
                    strb_d   = pstrb;
                    write_d  = pwrite;
                    cause_d  = setup_cause;
                    ctr_load = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        cause_d  = entry_cause;
                        prdata_d = entry_rdata;
                        state_d  = ST_RESP;
                    end else begin
                        state_d  = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!psel) begin
                    state_d = ST_IDLE;
                end else if (ctr_done) begin
                    cause_d  = entry_cause;
                    prdata_d = entry_rdata;
                    state_d  = ST_RESP;
                end else begin
                    ctr_dec = 1'b1;
                end
            end
            ST_RESP: begin
                state_d  = ST_IDLE;
                prdata_d = '0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            strb_q   <= '0;
            write_q  <= 1'b0;
            cause_q  <= '0;
            prdata_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            strb_q   <= strb_d;
            write_q  <= write_d;
            cause_q  <= cause_d;
            prdata_q <= prdata_d;
        end
    end

    apb_wait_ctr u_wait_ctr (
        .clk        (pclk),
        .rst_n      (prst_n),
        .load_i     (ctr_load),
        .load_val_i (CNT_W'(WAIT_CYCLES)),
        .dec_i      (ctr_dec),
        .done_o     (ctr_done)
    );

    assign pready    = (state_q == ST_RESP);
    assign pslverr   = pready && (|cause_q);
    assign reg_wr_en = pready && psel && penable && !(|cause_q) && write_q;
    assign reg_rd_en = pready && psel && penable && !(|cause_q) && !write_q;
    assign prdata    = prdata_q;
    assign reg_wdata = wdata_q;
    // The register file sees the incoming address during setup so zero-wait reads can be captured.
    assign reg_addr  = setup ? paddr : addr_q;

    for (genvar i = 0; i < PSTRB_SIZE; i++) begin : g_wmask
        assign reg_wmask[i*8 +: 8] = {8{strb_q[i]}};
    end

endmodule
